// File: rtl/lcd_hd44780_ctrl.sv
// HD44780-compatible character LCD controller, 8-bit bus, write-only.
// Runs the power-up/init sequence on its own, then serves host requests
// (raw instruction, or character at row/col) over a valid/ready handshake.
// Every bus transfer is SETUP -> PULSE -> HOLD -> WAIT, all cycle-timed.
module lcd_hd44780_ctrl #(
  parameter int unsigned COLS         = 16,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned PWRUP_CYC    = 2500000,
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned EN_CYC       = 25,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLR_WAIT_CYC = 100000,
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CLW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic           wr_cmd,
  input  logic [RW-1:0]  wr_row,
  input  logic [CLW-1:0] wr_col,
  input  logic [7:0]     wr_data,
  output logic           init_done,
  output logic           err,
  output logic           lcd_rs,
  output logic           lcd_rw,
  output logic           lcd_en,
  output logic [7:0]     lcd_db
);

  localparam int unsigned M1   = (PWRUP_CYC > SETUP_CYC) ? PWRUP_CYC : SETUP_CYC;
  localparam int unsigned M2   = (M1 > EN_CYC) ? M1 : EN_CYC;
  localparam int unsigned M3   = (M2 > HOLD_CYC) ? M2 : HOLD_CYC;
  localparam int unsigned M4   = (M3 > CMD_WAIT_CYC) ? M3 : CMD_WAIT_CYC;
  localparam int unsigned MAXC = (M4 > CLR_WAIT_CYC) ? M4 : CLR_WAIT_CYC;
  localparam int unsigned CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [1:0]      ini_idx;
  logic            pend;     // character byte still to follow the address byte
  logic            long_w;   // current byte needs the clear/home execution wait
  logic            cmd_r;
  logic [RW-1:0]   row_r;
  logic [CLW-1:0]  col_r;
  logic [7:0]      data_r;

  function automatic logic [CNTW-1:0] last(input int unsigned n);
    return CNTW'(n - 1);
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [6:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 7'h00;
      2'd1:    return 7'h40;
      2'd2:    return 7'h14;
      default: return 7'h54;
    endcase
  endfunction

  function automatic logic is_long(input logic rs, input logic [7:0] db);
    return !rs && (db == 8'h01 || db == 8'h02 || db == 8'h03);
  endfunction

  logic       bad_req;
  logic [7:0] ddram_cmd;

  assign bad_req   = !wr_cmd && ((32'(wr_row) >= ROWS) || (32'(wr_col) >= COLS));
  assign ddram_cmd = 8'h80 | {1'b0, row_base(2'(row_r)) + 7'(col_r)};
  assign lcd_rw    = 1'b0;

  // Sequencer: power-up delay, init bytes, host requests and bus timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PWRUP;
      cnt       <= '0;
      ini_idx   <= '0;
      pend      <= 1'b0;
      long_w    <= 1'b0;
      cmd_r     <= 1'b0;
      row_r     <= '0;
      col_r     <= '0;
      data_r    <= '0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_db    <= '0;
    end else begin
      case (state)
        S_PWRUP: begin
          if (cnt == last(PWRUP_CYC)) begin
            cnt   <= '0;
            state <= S_INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_INIT: begin
          ini_idx <= '0;
          lcd_rs  <= 1'b0;
          lcd_db  <= init_byte(2'd0);
          long_w  <= is_long(1'b0, init_byte(2'd0));
          cnt     <= '0;
          state   <= S_SETUP;
        end
        S_IDLE: begin
          if (wr_valid && wr_ready) begin
            cmd_r    <= wr_cmd;
            row_r    <= wr_row;
            col_r    <= wr_col;
            data_r   <= wr_data;
            err      <= bad_req;
            wr_ready <= 1'b0;
            state    <= S_ADDR;
          end
        end
        // err doubles as the rejected-request flag for this one cycle
        S_ADDR: begin
          err <= 1'b0;
          cnt <= '0;
          if (err) begin
            wr_ready <= 1'b1;
            state    <= S_IDLE;
          end else if (cmd_r) begin
            lcd_rs <= 1'b0;
            lcd_db <= data_r;
            long_w <= is_long(1'b0, data_r);
            pend   <= 1'b0;
            state  <= S_SETUP;
          end else begin
            lcd_rs <= 1'b0;
            lcd_db <= ddram_cmd;
            long_w <= is_long(1'b0, ddram_cmd);
            pend   <= 1'b1;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == last(SETUP_CYC)) begin
            cnt    <= '0;
            lcd_en <= 1'b1;
            state  <= S_PULSE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == last(EN_CYC)) begin
            cnt    <= '0;
            lcd_en <= 1'b0;
            state  <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == last(HOLD_CYC)) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // End of a transfer chains straight into the next byte's SETUP
        S_WAIT: begin
          if (cnt == (long_w ? last(CLR_WAIT_CYC) : last(CMD_WAIT_CYC))) begin
            cnt <= '0;
            if (!init_done) begin
              if (ini_idx == 2'd3) begin
                init_done <= 1'b1;
                wr_ready  <= 1'b1;
                state     <= S_IDLE;
              end else begin
                ini_idx <= ini_idx + 2'd1;
                lcd_rs  <= 1'b0;
                lcd_db  <= init_byte(ini_idx + 2'd1);
                long_w  <= is_long(1'b0, init_byte(ini_idx + 2'd1));
                state   <= S_SETUP;
              end
            end else if (pend) begin
              pend   <= 1'b0;
              lcd_rs <= 1'b1;
              lcd_db <= data_r;
              long_w <= is_long(1'b1, data_r);
              state  <= S_SETUP;
            end else begin
              wr_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Bench for lcd_hd44780_ctrl: a per-cycle expected-output timeline is built
// from the transfer rules (queue of expected samples) and checked every cycle,
// plus literal checks on captured en pulses and wr_ready-low durations.
module tb_lcd_hd44780_ctrl;

  localparam int unsigned COLS = 20;
  localparam int unsigned ROWS = 4;
  localparam int unsigned PW   = 100;
  localparam int unsigned SC   = 2;
  localparam int unsigned EC   = 4;
  localparam int unsigned HC   = 2;
  localparam int unsigned CW   = 10;
  localparam int unsigned LW   = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_cmd = 1'b0;
  logic [1:0] wr_row = '0;
  logic [4:0] wr_col = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, init_done, err, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_db;

  always #5 clk = ~clk;

  lcd_hd44780_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .PWRUP_CYC(PW), .SETUP_CYC(SC), .EN_CYC(EC),
    .HOLD_CYC(HC), .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_cmd(wr_cmd), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .init_done(init_done), .err(err), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_db(lcd_db)
  );

  typedef struct packed {
    logic       rs;
    logic [7:0] db;
    logic       en;
    logic       rdy;
    logic       err;
    logic       idn;
  } exp_t;

  exp_t       q[$];
  exp_t       ce;
  logic [8:0] cap[$];
  logic [7:0] row_base [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  int   n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0;
  int   low_cnt = 0, last_low = 0;
  logic m_rs = 1'b0, m_idn = 1'b0;
  logic [7:0] m_db = '0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic en, input logic rdy, input logic er);
    exp_t e;
    e.rs = m_rs; e.db = m_db; e.en = en; e.rdy = rdy; e.err = er; e.idn = m_idn;
    q.push_back(e);
    n_push++;
  endtask

  // One byte on the bus: setup, enable, hold, then execution wait
  task automatic push_xfer(input logic rs, input logic [7:0] db);
    m_rs = rs;
    m_db = db;
    repeat (SC) push(1'b0, 1'b0, 1'b0);
    repeat (EC) push(1'b1, 1'b0, 1'b0);
    repeat (HC) push(1'b0, 1'b0, 1'b0);
    repeat ((!rs && db >= 8'h01 && db <= 8'h03) ? LW : CW) push(1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_init();
    logic [7:0] ib [4];
    ib = '{8'h38, 8'h0C, 8'h01, 8'h06};
    m_rs = 1'b0; m_db = 8'h00; m_idn = 1'b0;
    repeat (PW) push(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push_xfer(1'b0, ib[i]);
    m_idn = 1'b1;
    push(1'b0, 1'b1, 1'b0);
  endtask

  // Accept cycle, the transfers, then the single ready cycle that follows
  task automatic push_req(input logic cmd, input int row, input int col,
                          input logic [7:0] data, output int idx);
    logic bad;
    bad = !cmd && (row >= ROWS || col >= COLS);
    idx = n_push;
    push(1'b0, 1'b0, bad);
    if (!bad) begin
      if (cmd) push_xfer(1'b0, data);
      else begin
        push_xfer(1'b0, 8'h80 | (row_base[row] + 8'(col)));
        push_xfer(1'b1, data);
      end
    end
    push(1'b0, 1'b1, 1'b0);
  endtask

  task automatic wait_idx(input int idx);
    int t = 0;
    while (n_pop <= idx && t < 3000) begin @(negedge clk); t++; end
    if (n_pop <= idx) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() > 0 && t < 5000) begin @(negedge clk); t++; end
    if (q.size() > 0) chk("drain_timeout", 0, 1);
  endtask

  task automatic drive(input logic cmd, input int row, input int col, input logic [7:0] data);
    wr_cmd = cmd; wr_row = 2'(row); wr_col = 5'(col); wr_data = data;
  endtask

  task automatic req(input logic cmd, input int row, input int col, input logic [7:0] data);
    int idx;
    push_req(cmd, row, col, data, idx);
    drive(cmd, row, col, data);
    wr_valid = 1'b1;
    wait_idx(idx);
    wr_valid = 1'b0;
    wait_drain();
  endtask

  task automatic chk_cap(input int i, input logic [8:0] exp);
    if (i < cap.size()) chk($sformatf("cap%0d", i), 32'(cap[i]), 32'(exp));
    else chk($sformatf("cap%0d_missing", i), 0, 1);
  endtask

  always @(posedge lcd_en) cap.push_back({lcd_rs, lcd_db});

  // Per-cycle compare against the expected timeline
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      if (q.size() > 0) begin
        ce = q.pop_front();
        n_pop++;
      end else begin
        ce.rs = m_rs; ce.db = m_db; ce.en = 1'b0;
        ce.rdy = m_idn; ce.err = 1'b0; ce.idn = m_idn;
      end
      chk("cycle{rw,rs,db,en,rdy,err,done}",
          32'({lcd_rw, lcd_rs, lcd_db, lcd_en, wr_ready, err, init_done}),
          32'({1'b0, ce.rs, ce.db, ce.en, ce.rdy, ce.err, ce.idn}));
      if (!wr_ready) low_cnt++;
      else if (low_cnt > 0) begin last_low = low_cnt; low_cnt = 0; end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    #2;
    chk("reset_outputs", 32'({lcd_rw, lcd_rs, lcd_db, lcd_en, wr_ready, err, init_done}), 0);

    // Request held during power-up/init must wait until init completes
    drive(1'b1, 0, 0, 8'h0C);
    wr_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    push_init();
    chk("model_init_len", q.size(), 213);
    push_req(1'b1, 0, 0, 8'h0C, idx);
    rst_n = 1'b1;
    chk_en = 1'b1;
    wait_idx(idx);
    wr_valid = 1'b0;
    wait_drain();
    chk("init_pulses", cap.size(), 5);
    chk_cap(0, 9'h038); chk_cap(1, 9'h00C); chk_cap(2, 9'h001);
    chk_cap(3, 9'h006); chk_cap(4, 9'h00C);
    chk("ready_low_0C", last_low, 19);

    cap.delete();
    req(1'b0, 1, 3, 8'h41);
    chk("char_pulses", cap.size(), 2);
    chk_cap(0, 9'h0C3); chk_cap(1, 9'h141);
    chk("ready_low_char", last_low, 37);

    cap.delete();
    req(1'b1, 0, 0, 8'h01);
    chk_cap(0, 9'h001);
    chk("ready_low_clear", last_low, 59);

    cap.delete();
    req(1'b0, 0, 20, 8'h55);
    chk("err_no_pulse", cap.size(), 0);
    chk("ready_low_err", last_low, 1);

    req(1'b0, 2, 0, 8'h5A);
    chk_cap(0, 9'h094); chk_cap(1, 9'h15A);

    cap.delete();
    req(1'b1, 0, 0, 8'h02);
    chk("ready_low_home", last_low, 59);

    // wr_valid held high over three character writes
    cap.delete();
    push_req(1'b0, 0, 0, 8'h48, idx); drive(1'b0, 0, 0, 8'h48); wr_valid = 1'b1; wait_idx(idx);
    push_req(1'b0, 3, 19, 8'h21, idx); drive(1'b0, 3, 19, 8'h21); wait_idx(idx);
    push_req(1'b0, 1, 0, 8'h01, idx); drive(1'b0, 1, 0, 8'h01); wait_idx(idx);
    wr_valid = 1'b0;
    wait_drain();
    chk("held_pulses", cap.size(), 6);
    chk_cap(0, 9'h080); chk_cap(1, 9'h148); chk_cap(2, 9'h0E7);
    chk_cap(3, 9'h121); chk_cap(4, 9'h0C0); chk_cap(5, 9'h101);
    chk("ready_low_data01", last_low, 37);

    // Reset while en is high
    cap.delete();
    push_req(1'b0, 2, 5, 8'h33, idx); drive(1'b0, 2, 5, 8'h33); wr_valid = 1'b1; wait_idx(idx);
    wr_valid = 1'b0;
    for (int t = 0; t < 100 && !lcd_en; t++) @(negedge clk);
    chk("en_seen_before_reset", lcd_en, 1);
    chk_cap(0, 9'h099);
    chk_en = 1'b0;
    q.delete();
    n_pop = n_push;
    rst_n = 1'b0;
    #1;
    chk("reset_async_en", lcd_en, 0);
    chk("reset_async_outputs", 32'({lcd_rw, lcd_rs, lcd_db, lcd_en, wr_ready, err, init_done}), 0);
    cap.delete();
    low_cnt = 0;
    repeat (3) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    chk_en = 1'b1;
    wait_drain();
    chk("reinit_pulses", cap.size(), 4);
    chk_cap(0, 9'h038); chk_cap(1, 9'h00C); chk_cap(2, 9'h001); chk_cap(3, 9'h006);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
